// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared types and defaults for the frequency measurement scheduler.
package freq_meas_pkg;
    localparam int CHW = 3;
    localparam int CW_DEF = 22;
    localparam logic [CW_DEF-1:0] TMO_DEF = 22'h3FFFFF;
    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ARM, S_COUNT, S_STORE, S_NEXT} state_e;
endpackage

// File: rtl/freq_sync_edge.sv
// freq_sync_edge: 2-FF synchronizer with a one-cycle rising-edge pulse.
module freq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic edge_o
);
    logic [2:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else sync_q <= {sync_q[1:0], async_i};
    end
    assign edge_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/freq_meas_sched.sv
// freq_meas_sched: round-robin period measurement across NCH async inputs
// with settle, timeout and a per-channel result bank.
module freq_meas_sched
    import freq_meas_pkg::*;
#(
    parameter int NCH = 3,
    parameter int CW = CW_DEF,
    parameter int SETTLE = 4,
    parameter logic [CW-1:0] TMO = CW'(TMO_DEF)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] freq_in,
    input  logic [NCH-1:0] ch_mask,
    input  logic           start,
    input  logic           cont_en,
    output logic           busy,
    output logic [CHW-1:0] cur_ch,
    output logic           done,
    output logic           upd,
    output logic [CHW-1:0] upd_ch,
    input  logic [CHW-1:0] rd_sel,
    output logic [CW-1:0]  rd_data,
    output logic           rd_valid,
    output logic           rd_tmo
);
    state_e state_q, state_d;
    logic [NCH-1:0] ep, mask_q, mask_d;
    logic [7:0] ep_x, mask_x, live_x;
    logic [CHW-1:0] cur_ch_q, cur_ch_d, nxt_ch, low_ch, upd_ch_q;
    logic nxt_found, ep_cur, to_q, to_d, upd_q;
    logic [CW-1:0] cnt_q, cnt_d, wd_q, wd_d, meas_q, meas_d;
    logic [7:0][CW-1:0] res_q;
    logic [7:0] vld_q, tmo_q;

    for (genvar i = 0; i < NCH; i++) begin : g_sync
        freq_sync_edge u_sync (.clk(clk), .rst_n(rst_n), .async_i(freq_in[i]), .edge_o(ep[i]));
    end

    // Widen to 8 entries so a 3-bit channel index always addresses in range.
    assign ep_x = 8'(ep);
    assign mask_x = 8'(mask_q);
    assign live_x = 8'(ch_mask);
    assign ep_cur = ep_x[cur_ch_q];

    always_comb begin
        nxt_found = 1'b0;
        nxt_ch = '0;
        low_ch = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_x[i] && CHW'(i) > cur_ch_q) begin
                nxt_found = 1'b1;
                nxt_ch = CHW'(i);
            end
            if (live_x[i]) low_ch = CHW'(i);
        end
    end

    // wd_q doubles as settle counter in SELECT and watchdog in ARM/COUNT.
    always_comb begin
        state_d = state_q;
        cur_ch_d = cur_ch_q;
        mask_d = mask_q;
        cnt_d = cnt_q;
        wd_d = wd_q + 1'b1;
        meas_d = meas_q;
        to_d = to_q;
        done = 1'b0;
        case (state_q)
            S_IDLE: if (start && |ch_mask) begin
                mask_d = ch_mask;
                cur_ch_d = low_ch;
                wd_d = '0;
                state_d = S_SELECT;
            end
            S_SELECT: if (wd_q == CW'(SETTLE - 1)) begin
                wd_d = '0;
                state_d = S_ARM;
            end
            S_ARM: if (ep_cur) begin
                cnt_d = CW'(1);
                wd_d = '0;
                state_d = S_COUNT;
            end else if (wd_q == TMO) begin
                meas_d = '0;
                to_d = 1'b1;
                state_d = S_STORE;
            end
            S_COUNT: begin
                cnt_d = cnt_q + 1'b1;
                if (ep_cur) begin
                    meas_d = cnt_q;
                    to_d = 1'b0;
                    state_d = S_STORE;
                end else if (wd_q == TMO) begin
                    meas_d = '0;
                    to_d = 1'b1;
                    state_d = S_STORE;
                end
            end
            S_STORE: state_d = S_NEXT;
            S_NEXT: if (nxt_found) begin
                cur_ch_d = nxt_ch;
                wd_d = '0;
                state_d = S_SELECT;
            end else begin
                done = 1'b1;
                if (cont_en && |ch_mask) begin
                    mask_d = ch_mask;
                    cur_ch_d = low_ch;
                    wd_d = '0;
                    state_d = S_SELECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cur_ch_q <= '0;
            mask_q <= '0;
            cnt_q <= '0;
            wd_q <= '0;
            meas_q <= '0;
            to_q <= 1'b0;
            upd_q <= 1'b0;
            upd_ch_q <= '0;
            res_q <= '0;
            vld_q <= '0;
            tmo_q <= '0;
        end else begin
            state_q <= state_d;
            cur_ch_q <= cur_ch_d;
            mask_q <= mask_d;
            cnt_q <= cnt_d;
            wd_q <= wd_d;
            meas_q <= meas_d;
            to_q <= to_d;
            upd_q <= state_q == S_STORE;
            if (state_q == S_STORE) begin
                upd_ch_q <= cur_ch_q;
                res_q[cur_ch_q] <= meas_q;
                vld_q[cur_ch_q] <= ~to_q;
                tmo_q[cur_ch_q] <= to_q;
            end
        end
    end

    assign busy = state_q != S_IDLE;
    assign cur_ch = cur_ch_q;
    assign upd = upd_q;
    assign upd_ch = upd_ch_q;
    assign rd_data = res_q[rd_sel];
    assign rd_valid = vld_q[rd_sel];
    assign rd_tmo = tmo_q[rd_sel];
endmodule

// File: tb/tb_freq_meas_sched.sv
// tb_freq_meas_sched: table-driven sweeps with an update scoreboard plus
// continuous-mode, reset and empty-mask sequences.
module tb_freq_meas_sched;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont_en = 1'b0;
    logic [2:0] freq_in = '0, ch_mask = '0, rd_sel = '0;
    logic busy, done, upd, rd_valid, rd_tmo;
    logic [2:0] cur_ch, upd_ch;
    logic [21:0] rd_data;

    freq_meas_sched #(.NCH(3), .CW(22), .SETTLE(4), .TMO(22'd2000)) dut (
        .clk(clk), .rst_n(rst_n), .freq_in(freq_in), .ch_mask(ch_mask), .start(start),
        .cont_en(cont_en), .busy(busy), .cur_ch(cur_ch), .done(done), .upd(upd),
        .upd_ch(upd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid), .rd_tmo(rd_tmo)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [2:0] ch; logic [21:0] data; logic v; logic t;} exp_t;
    typedef struct {logic [2:0] mask; int p0, p1, p2, e0, e1, e2; logic [2:0] t;} vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vt[5];
    int checks = 0, errors = 0, done_cnt = 0;
    int per[3] = '{0, 0, 0};
    int ph[3] = '{0, 0, 0};
    logic [21:0] sh_d[8];
    logic sh_v[8], sh_t[8];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", nm, act, exp);
        end
    endtask

    // Square waves change on the falling clk edge so every period is exact in clk cycles.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (per[i] == 0) begin
                ph[i] = 0;
                freq_in[i] = 1'b0;
            end else begin
                ph[i] = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
                freq_in[i] = ph[i] < per[i] / 2;
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (upd) begin
            if (sbq.size() == 0) chk("upd_unexpected", 1, 0);
            else begin
                mon_e = sbq.pop_front();
                chk("upd_ch", upd_ch, mon_e.ch);
                rd_sel = upd_ch;
                #1;
                chk("upd_data", rd_data, mon_e.data);
                chk("upd_valid", rd_valid, mon_e.v);
                chk("upd_tmo", rd_tmo, mon_e.t);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(posedge clk);
            #1;
            if (done) ok = 1'b1;
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic push_sweep(input vec_t v);
        int e;
        for (int i = 0; i < 3; i++) begin
            if (v.mask[i]) begin
                e = (i == 0) ? v.e0 : (i == 1) ? v.e1 : v.e2;
                sbq.push_back({3'(i), 22'(e), ~v.t[i], v.t[i]});
                sh_d[i] = 22'(e);
                sh_v[i] = ~v.t[i];
                sh_t[i] = v.t[i];
            end
        end
    endtask

    task automatic check_bank();
        int sel[5] = '{0, 1, 2, 3, 7};
        for (int k = 0; k < 5; k++) begin
            rd_sel = 3'(sel[k]);
            #1;
            chk($sformatf("bank_data%0d", sel[k]), rd_data, sh_d[sel[k]]);
            chk($sformatf("bank_valid%0d", sel[k]), rd_valid, sh_v[sel[k]]);
            chk($sformatf("bank_tmo%0d", sel[k]), rd_tmo, sh_t[sel[k]]);
        end
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < 8; i++) begin
            sh_d[i] = '0;
            sh_v[i] = 1'b0;
            sh_t[i] = 1'b0;
        end
    endtask

    initial begin
        int d0;
        vt[0] = '{3'b001, 1000, 0, 0, 1000, 0, 0, 3'b000};
        vt[1] = '{3'b111, 500, 800, 1200, 500, 800, 1200, 3'b000};
        vt[2] = '{3'b101, 300, 700, 900, 300, 0, 900, 3'b000};
        vt[3] = '{3'b100, 300, 700, 0, 0, 0, 0, 3'b100};
        vt[4] = '{3'b011, 2, 1999, 0, 2, 1999, 0, 3'b000};
        clear_shadow();
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_upd", upd, 0);
        chk("rst_cur_ch", cur_ch, 0);
        chk("rst_upd_ch", upd_ch, 0);
        check_bank();
        rst_n = 1'b1;
        cyc(2);

        for (int v = 0; v < 5; v++) begin
            per[0] = vt[v].p0;
            per[1] = vt[v].p1;
            per[2] = vt[v].p2;
            ch_mask = vt[v].mask;
            cyc(10);
            d0 = done_cnt;
            push_sweep(vt[v]);
            pulse_start();
            chk("busy_after_start", busy, 1);
            wait_done(20000);
            cyc(1);
            chk("busy_after_done", busy, 0);
            cyc(5);
            chk("done_once", done_cnt - d0, 1);
            chk("sb_empty", sbq.size(), 0);
            check_bank();
        end

        per[0] = 200;
        per[1] = 300;
        per[2] = 0;
        ch_mask = 3'b011;
        cont_en = 1'b1;
        cyc(10);
        d0 = done_cnt;
        repeat (4) push_sweep('{3'b011, 200, 300, 0, 200, 300, 0, 3'b000});
        pulse_start();
        wait_done(5000);
        wait_done(5000);
        wait_done(5000);
        cyc(50);
        chk("cont_still_busy", busy, 1);
        cont_en = 1'b0;
        wait_done(5000);
        cyc(1);
        chk("cont_busy_after", busy, 0);
        cyc(5);
        chk("cont_done_total", done_cnt - d0, 4);
        chk("cont_sb_empty", sbq.size(), 0);

        per[0] = 1000;
        ch_mask = 3'b001;
        cyc(10);
        pulse_start();
        cyc(600);
        chk("pre_rst_busy", busy, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_upd", upd, 0);
        chk("arst_done", done, 0);
        chk("arst_cur_ch", cur_ch, 0);
        chk("arst_upd_ch", upd_ch, 0);
        clear_shadow();
        check_bank();
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        ch_mask = 3'b000;
        d0 = done_cnt;
        pulse_start();
        cyc(20);
        chk("mask0_busy", busy, 0);
        chk("mask0_no_done", done_cnt - d0, 0);
        chk("final_sb_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
